bimodal_gshare_predictor: RTL and testbench

- Parametrised successor of the single-counter branch predictor.
- Holds a pattern history table (PHT) of 2^IDX_W saturating counters, each CTR_W bits wide.
- The PHT is indexed by PC bits, optionally XORed with a global history register (GHR). HIST_W=0 gives a pure bimodal predictor.
- Sits beside fetch: fetch issues prediction requests, and the branch-resolve stage returns outcomes.

---
 rtl/bp_pkg.sv | 33 +++
 rtl/bimodal_gshare_predictor_if.sv | 27 ++
 rtl/bp_sat_counter_table.sv | 39 +++
 rtl/bimodal_gshare_predictor.sv | 142 ++++++++++++++
 tb/tb_bimodal_gshare_predictor.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions: FSM states, default widths and the
// saturating counter step used by every counter-table based predictor.
package bp_pkg;

    localparam int BP_PC_W      = 32;
    localparam int BP_IDX_W     = 6;
    localparam int BP_CTR_W     = 2;
    localparam int BP_HIST_W    = 4;
    localparam int BP_CTR_MAX_W = 8;

    typedef enum logic [0:0] {
        BP_INIT = 1'b0,
        BP_RUN  = 1'b1
    } bp_state_e;

    // Saturation is tested before stepping so the counter can never wrap.
    function automatic logic [BP_CTR_MAX_W-1:0] bp_sat_step(
        input logic [BP_CTR_MAX_W-1:0] ctr,
        input logic [BP_CTR_MAX_W-1:0] ctr_max,
        input logic                    up
    );
        logic [BP_CTR_MAX_W-1:0] res;
        if (up) begin
            if (ctr >= ctr_max) res = ctr_max;
            else                res = ctr + 8'd1;
        end else begin
            if (ctr == 8'd0)    res = 8'd0;
            else                res = ctr - 8'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/bimodal_gshare_predictor_if.sv
// Fetch-side request/prediction and resolve-side update bundle of the predictor.
interface bimodal_gshare_predictor_if
    import bp_pkg::*;
#(
    parameter int PC_W  = BP_PC_W,
    parameter int IDX_W = BP_IDX_W
);
    logic             ready;
    logic             req_valid;
    logic [PC_W-1:0]  req_pc;
    logic             pred_valid;
    logic             pred_taken;
    logic [IDX_W-1:0] pred_idx;
    logic             upd_valid;
    logic [IDX_W-1:0] upd_idx;
    logic             upd_taken;

    modport master (
        input  ready, pred_valid, pred_taken, pred_idx,
        output req_valid, req_pc, upd_valid, upd_idx, upd_taken
    );

    modport slave (
        output ready, pred_valid, pred_taken, pred_idx,
        input  req_valid, req_pc, upd_valid, upd_idx, upd_taken
    );
endinterface

// File: rtl/bp_sat_counter_table.sv
// Pattern history table: 2^IDX_W saturating counters, one combinational read
// port and one write port shared by initialisation fill and outcome updates.
module bp_sat_counter_table
    import bp_pkg::*;
#(
    parameter int IDX_W    = BP_IDX_W,
    parameter int CTR_W    = BP_CTR_W,
    parameter int INIT_CTR = (2 ** CTR_W) - 1
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic             i_init,
    input  logic [IDX_W-1:0] i_waddr,
    input  logic             i_up,
    input  logic [IDX_W-1:0] i_raddr,
    output logic [CTR_W-1:0] o_rdata
);
    localparam int               DEPTH    = 2 ** IDX_W;
    localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(INIT_CTR);

    logic [CTR_W-1:0]        r_pht [DEPTH];
    logic [CTR_W-1:0]        w_cur;
    logic [BP_CTR_MAX_W-1:0] w_step_full;
    logic [CTR_W-1:0]        w_wdata;

    assign w_cur       = r_pht[i_waddr];
    assign w_step_full = bp_sat_step(BP_CTR_MAX_W'(w_cur), BP_CTR_MAX_W'(CTR_MAX), i_up);
    assign w_wdata     = i_init ? CTR_INIT : CTR_W'(w_step_full);
    assign o_rdata     = r_pht[i_raddr];

    // Single write port: init fill and resolve updates never coincide.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_pht[i_waddr] <= w_wdata;
        end
    end

endmodule

// File: rtl/bimodal_gshare_predictor.sv
// Bimodal / gshare direction predictor: init FSM, global history, index hash
// and registered prediction outputs around a saturating counter table.
module bimodal_gshare_predictor
    import bp_pkg::*;
#(
    parameter int PC_W     = BP_PC_W,
    parameter int IDX_W    = BP_IDX_W,
    parameter int CTR_W    = BP_CTR_W,
    parameter int HIST_W   = BP_HIST_W,
    parameter int INIT_CTR = (2 ** CTR_W) - 1
) (
    input  logic                       clk,
    input  logic                       rst,
    bimodal_gshare_predictor_if.slave  bus
);
    bp_state_e        r_state;
    bp_state_e        w_state_next;
    logic [IDX_W-1:0] r_init_ptr;
    logic             r_ready;
    logic             r_pred_valid;
    logic             r_pred_taken;
    logic [IDX_W-1:0] r_pred_idx;

    logic             w_init_we;
    logic             w_init_done;
    logic             w_req_fire;
    logic             w_upd_fire;
    logic [IDX_W-1:0] w_pc_idx;
    logic [IDX_W-1:0] w_hist_ext;
    logic [IDX_W-1:0] w_idx;
    logic [IDX_W-1:0] w_waddr;
    logic [CTR_W-1:0] w_rdata;
    logic             w_unused_pc_bits;

    assign w_pc_idx         = bus.req_pc[IDX_W+1:2];
    assign w_unused_pc_bits = ^{bus.req_pc[PC_W-1:IDX_W+2], bus.req_pc[1:0]};

    generate
        if (HIST_W > 0) begin : g_ghr
            logic [HIST_W-1:0] r_ghr;
            logic [HIST_W:0]   w_shift;

            assign w_shift    = {r_ghr, bus.upd_taken};
            assign w_hist_ext = IDX_W'(r_ghr);

            // History is non-speculative: it only shifts on a resolved branch.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ghr <= {HIST_W{1'b0}};
                end else if (w_upd_fire) begin
                    r_ghr <= HIST_W'(w_shift);
                end
            end
        end else begin : g_nohist
            assign w_hist_ext = {IDX_W{1'b0}};
        end
    endgenerate

    assign w_idx = w_pc_idx ^ w_hist_ext;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= BP_INIT;
        else     r_state <= w_state_next;
    end

    // FSM next state: leave INIT after the last entry has been written.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            BP_INIT: begin
                if (r_init_ptr == {IDX_W{1'b1}}) w_state_next = BP_RUN;
                else                             w_state_next = BP_INIT;
            end
            BP_RUN:  w_state_next = BP_RUN;
            default: w_state_next = BP_INIT;
        endcase
    end

    // FSM outputs: requests and updates are only honoured in RUN.
    always_comb begin
        w_init_we   = 1'b0;
        w_init_done = 1'b0;
        w_req_fire  = 1'b0;
        w_upd_fire  = 1'b0;
        case (r_state)
            BP_INIT: begin
                w_init_we   = 1'b1;
                w_init_done = (r_init_ptr == {IDX_W{1'b1}});
            end
            BP_RUN: begin
                w_req_fire = bus.req_valid;
                w_upd_fire = bus.upd_valid;
            end
            default: begin
                w_init_we = 1'b0;
            end
        endcase
    end

    assign w_waddr = w_init_we ? r_init_ptr : bus.upd_idx;

    bp_sat_counter_table #(
        .IDX_W    (IDX_W),
        .CTR_W    (CTR_W),
        .INIT_CTR (INIT_CTR)
    ) u_pht (
        .clk     (clk),
        .i_we    (w_init_we | w_upd_fire),
        .i_init  (w_init_we),
        .i_waddr (w_waddr),
        .i_up    (bus.upd_taken),
        .i_raddr (w_idx),
        .o_rdata (w_rdata)
    );

    // Init pointer, ready flag and prediction registers; the read sees the
    // pre-update counter, so a same-cycle update never bypasses into it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_init_ptr   <= {IDX_W{1'b0}};
            r_ready      <= 1'b0;
            r_pred_valid <= 1'b0;
            r_pred_taken <= 1'b0;
            r_pred_idx   <= {IDX_W{1'b0}};
        end else begin
            if (w_init_we)   r_init_ptr <= r_init_ptr + {{(IDX_W-1){1'b0}}, 1'b1};
            if (w_init_done) r_ready    <= 1'b1;
            r_pred_valid <= w_req_fire;
            if (w_req_fire) begin
                r_pred_taken <= w_rdata[CTR_W-1];
                r_pred_idx   <= w_idx;
            end
        end
    end

    assign bus.ready      = r_ready;
    assign bus.pred_valid = r_pred_valid;
    assign bus.pred_taken = r_pred_taken;
    assign bus.pred_idx   = r_pred_idx;

endmodule

// File: tb/tb_bimodal_gshare_predictor.sv
// Drives a gshare (HIST_W=4) and a bimodal (HIST_W=0) predictor with the same
// directed stimulus and checks both against a table-level reference model.
module tb_bimodal_gshare_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_pc;
    logic        upd_valid;
    logic [5:0]  upd_idx;
    logic        upd_taken;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    bimodal_gshare_predictor_if #(.PC_W(32), .IDX_W(6)) bus_a ();
    bimodal_gshare_predictor_if #(.PC_W(32), .IDX_W(6)) bus_b ();

    assign bus_a.req_valid = req_valid;
    assign bus_a.req_pc    = req_pc;
    assign bus_a.upd_valid = upd_valid;
    assign bus_a.upd_idx   = upd_idx;
    assign bus_a.upd_taken = upd_taken;
    assign bus_b.req_valid = req_valid;
    assign bus_b.req_pc    = req_pc;
    assign bus_b.upd_valid = upd_valid;
    assign bus_b.upd_idx   = upd_idx;
    assign bus_b.upd_taken = upd_taken;

    bimodal_gshare_predictor #(.PC_W(32), .IDX_W(6), .CTR_W(2), .HIST_W(4), .INIT_CTR(3))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    bimodal_gshare_predictor #(.PC_W(32), .IDX_W(6), .CTR_W(2), .HIST_W(0), .INIT_CTR(3))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: counters as plain ints, history as an int mod 16.
    int m_pht_a [64];
    int m_pht_b [64];
    int m_ghr, m_cnt;
    int m_ready;
    int m_pv, m_pt_a, m_pt_b, m_pidx_a, m_pidx_b;

    always @(posedge clk) begin
        int ia, ib, ui;
        if (rst) begin
            m_cnt = 0; m_ready = 0; m_ghr = 0; m_pv = 0;
            m_pt_a = 0; m_pt_b = 0; m_pidx_a = 0; m_pidx_b = 0;
        end else if (m_ready == 0) begin
            m_pht_a[m_cnt] = 3;
            m_pht_b[m_cnt] = 3;
            m_cnt = m_cnt + 1;
            if (m_cnt == 64) m_ready = 1;
            m_pv = 0;
        end else begin
            ib = (int'(req_pc) / 4) % 64;
            ia = ib ^ m_ghr;
            m_pv = req_valid ? 1 : 0;
            if (req_valid) begin
                m_pt_a = (m_pht_a[ia] >= 2) ? 1 : 0;
                m_pt_b = (m_pht_b[ib] >= 2) ? 1 : 0;
                m_pidx_a = ia;
                m_pidx_b = ib;
            end
            if (upd_valid) begin
                ui = int'(upd_idx);
                if (upd_taken) begin
                    if (m_pht_a[ui] < 3) m_pht_a[ui] = m_pht_a[ui] + 1;
                    if (m_pht_b[ui] < 3) m_pht_b[ui] = m_pht_b[ui] + 1;
                end else begin
                    if (m_pht_a[ui] > 0) m_pht_a[ui] = m_pht_a[ui] - 1;
                    if (m_pht_b[ui] > 0) m_pht_b[ui] = m_pht_b[ui] - 1;
                end
                m_ghr = (m_ghr * 2 + (upd_taken ? 1 : 0)) % 16;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("ready_a",      int'(bus_a.ready),      m_ready);
        chk("ready_b",      int'(bus_b.ready),      m_ready);
        chk("pred_valid_a", int'(bus_a.pred_valid), m_pv);
        chk("pred_valid_b", int'(bus_b.pred_valid), m_pv);
        chk("pred_taken_a", int'(bus_a.pred_taken), m_pt_a);
        chk("pred_taken_b", int'(bus_b.pred_taken), m_pt_b);
        chk("pred_idx_a",   int'(bus_a.pred_idx),   m_pidx_a);
        chk("pred_idx_b",   int'(bus_b.pred_idx),   m_pidx_b);
    end

    task automatic step(input bit rv, input logic [31:0] pc, input bit uv,
                        input logic [5:0] ui, input bit ut);
        req_valid = rv; req_pc = pc; upd_valid = uv; upd_idx = ui; upd_taken = ut;
        @(posedge clk); #1;
        req_valid = 1'b0; upd_valid = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        int seen_pv = 0;
        req_valid = 1'b1; req_pc = 32'h0000_0100;
        upd_valid = 1'b1; upd_idx = 6'd0; upd_taken = 1'b0;
        while (!bus_a.ready && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (bus_a.pred_valid || bus_b.pred_valid) seen_pv++;
        end
        req_valid = 1'b0; upd_valid = 1'b0;
        chk(name, n, 64);
        chk("no_pred_in_init", seen_pv, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_pc = 32'd0;
        upd_valid = 1'b0; upd_idx = 6'd0; upd_taken = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("ready_low_after_rst", int'(bus_a.ready), 0);
        wait_ready("init_cycles");

        // Default prediction at idx 0.
        step(1'b1, 32'h0000_0100, 1'b0, 6'd0, 1'b0);
        chk("dflt_pv_a", int'(bus_a.pred_valid), 1);
        chk("dflt_pt_a", int'(bus_a.pred_taken), 1);
        chk("dflt_idx_a", int'(bus_a.pred_idx), 0);
        chk("dflt_pt_b", int'(bus_b.pred_taken), 1);

        // Saturation and hysteresis on idx 0 (bimodal instance).
        repeat (2) step(1'b0, 32'd0, 1'b1, 6'd0, 1'b0);
        step(1'b1, 32'h0000_0100, 1'b0, 6'd0, 1'b0);
        chk("nt2_pt_b", int'(bus_b.pred_taken), 0);
        repeat (3) step(1'b0, 32'd0, 1'b1, 6'd0, 1'b0);
        step(1'b0, 32'd0, 1'b1, 6'd0, 1'b1);
        step(1'b1, 32'h0000_0100, 1'b0, 6'd0, 1'b0);
        chk("floor_t1_pt_b", int'(bus_b.pred_taken), 0);
        step(1'b0, 32'd0, 1'b1, 6'd0, 1'b1);
        step(1'b1, 32'h0000_0100, 1'b0, 6'd0, 1'b0);
        chk("floor_t2_pt_b", int'(bus_b.pred_taken), 1);
        repeat (5) step(1'b0, 32'd0, 1'b1, 6'd2, 1'b1);
        step(1'b1, 32'h0000_0108, 1'b0, 6'd0, 1'b0);
        chk("ceil_pt_b", int'(bus_b.pred_taken), 1);
        step(1'b0, 32'd0, 1'b1, 6'd2, 1'b0);
        step(1'b1, 32'h0000_0108, 1'b0, 6'd0, 1'b0);
        chk("ceil_n1_pt_b", int'(bus_b.pred_taken), 1);
        step(1'b0, 32'd0, 1'b1, 6'd2, 1'b0);
        step(1'b1, 32'h0000_0108, 1'b0, 6'd0, 1'b0);
        chk("ceil_n2_pt_b", int'(bus_b.pred_taken), 0);

        // Same-cycle predict and update on idx 5, counter at 2.
        step(1'b0, 32'd0, 1'b1, 6'd5, 1'b0);
        step(1'b1, 32'h0000_0114, 1'b1, 6'd5, 1'b0);
        chk("coll_old_pt_b", int'(bus_b.pred_taken), 1);
        chk("coll_idx_b", int'(bus_b.pred_idx), 5);
        step(1'b1, 32'h0000_0114, 1'b0, 6'd0, 1'b0);
        chk("coll_new_pt_b", int'(bus_b.pred_taken), 0);

        // History T,T,N,T -> 4'b1101, then hash pc 0x104.
        step(1'b0, 32'd0, 1'b1, 6'h30, 1'b1);
        step(1'b0, 32'd0, 1'b1, 6'h30, 1'b1);
        step(1'b0, 32'd0, 1'b1, 6'h30, 1'b0);
        step(1'b0, 32'd0, 1'b1, 6'h30, 1'b1);
        step(1'b1, 32'h0000_0104, 1'b0, 6'd0, 1'b0);
        chk("ghr_idx_a", int'(bus_a.pred_idx), 12);
        chk("ghr_idx_b", int'(bus_b.pred_idx), 1);
        step(1'b0, 32'h0000_0000, 1'b0, 6'd0, 1'b0);
        chk("hold_pv_a", int'(bus_a.pred_valid), 0);
        chk("hold_idx_a", int'(bus_a.pred_idx), 12);

        // Reset in RUN, then again after 30 init writes.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_run_ready", int'(bus_a.ready), 0);
        chk("rst_run_pidx", int'(bus_a.pred_idx), 0);
        repeat (30) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        wait_ready("reinit_cycles");
        step(1'b1, 32'h0000_0100, 1'b0, 6'd0, 1'b0);
        chk("reinit_idx0_pt_b", int'(bus_b.pred_taken), 1);
        step(1'b1, 32'h0000_0114, 1'b0, 6'd0, 1'b0);
        chk("reinit_idx5_pt_b", int'(bus_b.pred_taken), 1);
        step(1'b1, 32'h0000_0104, 1'b0, 6'd0, 1'b0);
        chk("reinit_ghr_idx_a", int'(bus_a.pred_idx), 1);
        chk("reinit_pt_a", int'(bus_a.pred_taken), 1);

        repeat (3) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
